// File: rtl/iob_cache_mem_arbiter_pkg.sv
// iob_cache_mem_arbiter_pkg: arbiter state encoding and width helper shared by the
// arbiter top and its round-robin encoder.
package iob_cache_mem_arbiter_pkg;
   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/iob_cache_mem_arbiter_rr_prio_enc.sv
// iob_rr_prio_enc: round-robin priority encoder; picks the first requester after
// the last grant, so the last winner is only re-picked when it is alone.
module iob_rr_prio_enc #(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] last_i,
   output logic [W-1:0] gnt_idx_o,
   output logic         any_req_o
);
   logic [W-1:0] idx;
   // scan downwards so the nearest index after last_i overwrites the others
   always_comb begin
      gnt_idx_o = last_i;
      idx = '0;
      for (int k = N; k >= 1; k--) begin
         idx = W'((int'(last_i) + k) % N);
         if (req_i[idx]) gnt_idx_o = idx;
      end
   end
   assign any_req_o = |req_i;
endmodule

// File: rtl/iob_cache_mem_arbiter.sv
// iob_cache_mem_arbiter: round-robin sharing of one native memory port between cache
// back-ends; a grant is held across bursts and capped only while others wait.
module iob_cache_mem_arbiter
   import iob_cache_mem_arbiter_pkg::*;
#(
   parameter  int N_MASTERS = 2,
   parameter  int ADDR_W    = 32,
   parameter  int DATA_W    = 32,
   parameter  int MAX_BEATS = 8,
   localparam int GRANT_W   = clog2_min1(N_MASTERS),
   localparam int CNT_W     = clog2_min1(MAX_BEATS)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_MASTERS-1:0]          m_valid,
   input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
   input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
   input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb,
   output logic [DATA_W-1:0]             m_rdata,
   output logic [N_MASTERS-1:0]          m_ready,
   output logic                          mem_valid,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [DATA_W-1:0]             mem_wdata,
   output logic [DATA_W/8-1:0]           mem_wstrb,
   input  logic [DATA_W-1:0]             mem_rdata,
   input  logic                          mem_ready,
   output logic [GRANT_W-1:0]            grant_id,
   output logic                          busy
);
   state_t               state_q, state_d;
   logic [GRANT_W-1:0]   grant_q, grant_d, nxt_idx;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [N_MASTERS-1:0] g_oh;
   logic                 any_req, g_valid, others, accept, at_cap;

   iob_rr_prio_enc #(.N(N_MASTERS), .W(GRANT_W)) u_enc (
      .req_i    (m_valid),
      .last_i   (grant_q),
      .gnt_idx_o(nxt_idx),
      .any_req_o(any_req)
   );

   // payload follows only the granted master, never the other requesters
   always_comb begin
      g_valid = 1'b0;
      mem_addr = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         if (grant_q == GRANT_W'(i)) begin
            g_valid = m_valid[i];
            mem_addr = m_addr[i*ADDR_W +: ADDR_W];
            mem_wdata = m_wdata[i*DATA_W +: DATA_W];
            mem_wstrb = m_wstrb[i*(DATA_W/8) +: DATA_W/8];
         end
      end
   end

   assign busy      = state_q == GRANT;
   assign g_oh      = N_MASTERS'(1) << grant_q;
   assign others    = |(m_valid & ~g_oh);
   assign mem_valid = busy & g_valid;
   assign accept    = mem_valid & mem_ready;
   assign at_cap    = cnt_q == CNT_W'(MAX_BEATS - 1);
   assign m_ready   = {N_MASTERS{accept}} & g_oh;
   assign m_rdata   = mem_rdata;
   assign grant_id  = grant_q;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      cnt_d = cnt_q;
      if (state_q == IDLE) begin
         if (any_req) begin
            state_d = GRANT;
            grant_d = nxt_idx;
            cnt_d = '0;
         end
      end else if (!g_valid || (accept && at_cap && others)) state_d = IDLE;
      else if (accept && !at_cap) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= GRANT_W'(N_MASTERS - 1);
         cnt_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: tb/tb_iob_cache_mem_arbiter.sv
// tb_iob_cache_mem_arbiter: directed bench; each master's beats are queued as stimulus
// and the expected service order is queued alongside, then checked per accepted beat.
`timescale 1ns/1ps
module tb_iob_cache_mem_arbiter;
   localparam int NM = 2, AW = 32, DW = 32, SW = DW / 8;

   typedef struct {
      int            mid;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] wstrb;
      logic [DW-1:0] rdata;
      int            gap;
   } beat_t;

   logic             clk = 1'b0, reset = 1'b1;
   logic [NM-1:0]    m_valid = '0;
   logic [NM*AW-1:0] m_addr = '0;
   logic [NM*DW-1:0] m_wdata = '0;
   logic [NM*SW-1:0] m_wstrb = '0;
   logic [DW-1:0]    m_rdata, mem_wdata, mem_rdata;
   logic [NM-1:0]    m_ready;
   logic             mem_valid, mem_ready, busy;
   logic [AW-1:0]    mem_addr;
   logic [SW-1:0]    mem_wstrb;
   logic [0:0]       grant_id;
   logic             ram_rdy;
   logic [DW-1:0]    ram [0:1023];
   logic [NM-1:0]    acc = '0;
   beat_t            mq0[$], mq1[$], exp_q[$];
   int               n_checks = 0, n_pass = 0, cyc = 0, last_acc = 0, n_acc = 0;

   iob_cache_mem_arbiter dut (
      .clk(clk), .reset(reset),
      .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_rdata(m_rdata), .m_ready(m_ready),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .grant_id(grant_id), .busy(busy)
   );

   always #5 clk = ~clk;

   // RAM answers one cycle after it sees a request, one beat per two cycles
   assign mem_ready = ram_rdy;
   assign mem_rdata = ram[mem_addr[9:0]];
   always @(posedge clk or posedge reset) begin
      if (reset) ram_rdy <= 1'b0;
      else ram_rdy <= mem_valid & ~ram_rdy;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      assert (got === want) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, got, want);
   endtask

   task automatic give(input int mid, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
      beat_t b;
      b = '{mid: mid, addr: a, wdata: d, wstrb: s, rdata: '0, gap: 0};
      if (mid == 0) mq0.push_back(b);
      else mq1.push_back(b);
   endtask

   task automatic expect_b(input int mid, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s, input int gap);
      exp_q.push_back('{mid: mid, addr: a, wdata: d, wstrb: s, rdata: ram[a[9:0]], gap: gap});
   endtask

   task automatic drive();
      m_valid[0] = mq0.size() > 0;
      m_valid[1] = mq1.size() > 0;
      if (mq0.size() > 0) begin
         m_addr[0 +: AW] = mq0[0].addr;
         m_wdata[0 +: DW] = mq0[0].wdata;
         m_wstrb[0 +: SW] = mq0[0].wstrb;
      end
      if (mq1.size() > 0) begin
         m_addr[AW +: AW] = mq1[0].addr;
         m_wdata[DW +: DW] = mq1[0].wdata;
         m_wstrb[SW +: SW] = mq1[0].wstrb;
      end
   endtask

   task automatic sample();
      beat_t e;
      @(negedge clk);
      cyc++;
      acc = m_ready;
      if (m_ready != '0) begin
         if (exp_q.size() == 0) chk("unexpected_beat", 64'(m_ready), 64'd0);
         else begin
            e = exp_q.pop_front();
            chk("m_ready", 64'(m_ready), 64'(NM'(1) << e.mid));
            chk("grant_id", 64'(grant_id), 64'(e.mid));
            chk("mem_addr", 64'(mem_addr), 64'(e.addr));
            chk("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
            chk("mem_wstrb", 64'(mem_wstrb), 64'(e.wstrb));
            chk("m_rdata", 64'(m_rdata), 64'(e.rdata));
            if (e.gap != 0) chk("beat_gap", 64'(cyc - last_acc), 64'(e.gap));
         end
         last_acc = cyc;
         n_acc++;
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      if (acc[0] && mq0.size() > 0) mq0.delete(0);
      if (acc[1] && mq1.size() > 0) mq1.delete(0);
      acc = '0;
      drive();
   endtask

   task automatic run_accepts(input int n, input int budget);
      int start, t;
      start = n_acc;
      t = 0;
      while (n_acc - start < n && t < budget) begin
         sample();
         advance();
         t++;
      end
      chk("accept_budget", 64'(n_acc - start), 64'(n));
   endtask

   task automatic run_done(input int budget);
      int t;
      t = 0;
      while (exp_q.size() > 0 && t < budget) begin
         sample();
         advance();
         t++;
      end
      chk("drain", 64'(exp_q.size()), 64'd0);
      repeat (3) begin
         sample();
         advance();
      end
      chk("idle_busy", 64'(busy), 64'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      mq0.delete();
      mq1.delete();
      exp_q.delete();
      acc = '0;
      m_valid = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_valid", 64'(mem_valid), 64'd0);
      chk("rst_m_ready", 64'(m_ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_grant_id", 64'(grant_id), 64'(NM - 1));
      reset = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = 32'hC0DE0000 | 32'(i);
      ram[10'h040] = 32'h11111111;
      ram[10'h044] = 32'h22222222;
      do_reset();

      // single write from master 0: one bubble, then a single beat
      give(0, 32'h10, 32'hDEAD, 4'hF);
      expect_b(0, 32'h10, 32'hDEAD, 4'hF, 0);
      drive();
      sample();
      chk("t1_bubble_valid", 64'(mem_valid), 64'd0);
      chk("t1_bubble_busy", 64'(busy), 64'd0);
      advance();
      sample();
      chk("t1_mem_valid", 64'(mem_valid), 64'd1);
      chk("t1_mem_addr", 64'(mem_addr), 64'h10);
      chk("t1_busy", 64'(busy), 64'd1);
      chk("t1_grant_id", 64'(grant_id), 64'd0);
      chk("t1_no_ready_yet", 64'(m_ready), 64'd0);
      advance();
      run_done(20);

      // simultaneous 4-beat reads from reset: master 0 burst, then master 1
      do_reset();
      for (int k = 0; k < 4; k++) begin
         give(0, 32'(k), '0, '0);
         give(1, 32'h100 + 32'(k), '0, '0);
      end
      for (int k = 0; k < 4; k++) expect_b(0, 32'(k), '0, '0, (k == 0) ? 0 : 2);
      for (int k = 0; k < 4; k++) expect_b(1, 32'h100 + 32'(k), '0, '0, (k == 0) ? 4 : 2);
      drive();
      run_done(60);

      // starvation cap: master 0 released after 8 beats once master 1 waits
      for (int k = 0; k < 20; k++) give(0, 32'h300 + 32'(k), '0, '0);
      for (int k = 0; k < 8; k++) expect_b(0, 32'h300 + 32'(k), '0, '0, (k == 0) ? 0 : 2);
      expect_b(1, 32'h200, '0, '0, 3);
      expect_b(1, 32'h201, '0, '0, 2);
      for (int k = 8; k < 20; k++) expect_b(0, 32'h300 + 32'(k), '0, '0, (k == 8) ? 4 : 2);
      drive();
      run_accepts(2, 20);
      give(1, 32'h200, '0, '0);
      give(1, 32'h201, '0, '0);
      drive();
      run_done(200);

      // sole requester past the cap keeps going; counter holds so a late rival wins at once
      for (int k = 0; k < 12; k++) give(0, 32'h380 + 32'(k), '0, '0);
      for (int k = 0; k < 11; k++) expect_b(0, 32'h380 + 32'(k), '0, '0, (k == 0) ? 0 : 2);
      expect_b(1, 32'h210, '0, '0, 3);
      expect_b(0, 32'h38B, '0, '0, 4);
      drive();
      run_accepts(10, 40);
      give(1, 32'h210, '0, '0);
      drive();
      run_done(60);

      // read data routing; master 0 won last, so master 1 goes first
      give(0, 32'h40, '0, '0);
      give(1, 32'h44, '0, '0);
      expect_b(1, 32'h44, '0, '0, 0);
      expect_b(0, 32'h40, '0, '0, 4);
      drive();
      run_done(40);

      // async reset in the middle of a granted beat
      for (int k = 0; k < 4; k++) give(0, 32'h80 + 32'(k), '0, '0);
      drive();
      sample();
      advance();
      sample();
      chk("t6_pre_valid", 64'(mem_valid), 64'd1);
      reset = 1'b1;
      #1;
      chk("t6_rst_mem_valid", 64'(mem_valid), 64'd0);
      chk("t6_rst_m_ready", 64'(m_ready), 64'd0);
      chk("t6_rst_busy", 64'(busy), 64'd0);
      chk("t6_rst_grant_id", 64'(grant_id), 64'd1);
      mq0.delete();
      exp_q.delete();
      acc = '0;
      m_valid = '0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      give(0, 32'h60, '0, '0);
      give(1, 32'h64, '0, '0);
      expect_b(0, 32'h60, '0, '0, 0);
      expect_b(1, 32'h64, '0, '0, 4);
      drive();
      run_done(40);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/iob_cache_mem_arbiter.md
Name: iob_cache_mem_arbiter

Overview:
Round-robin arbiter that shares one native back-end memory port between N cache back-ends, e.g. the instruction and data caches. It sits between the caches' mem_* native interfaces and the single RAM/AXI bridge. A grant is held across consecutive beats, such as a line fill or write-through burst, so that a line transfer is not interleaved. A beat cap forces re-arbitration so that no master starves another.

Parameters:
N_MASTERS, 2, number of requesters (2..8)
ADDR_W, 32, memory byte-address width
DATA_W, 32, memory data width; DATA_W/8 strobe bits
MAX_BEATS, 8, maximum accepted beats per grant while another master is pending (power of 2, ≥1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
m_valid  in  N_MASTERS  per-master request
m_addr  in  N_MASTERS*ADDR_W  per-master address; master i at [i*ADDR_W +: ADDR_W]
m_wdata  in  N_MASTERS*DATA_W  per-master write data
m_wstrb  in  N_MASTERS*DATA_W/8  per-master byte strobes; 0 means read
m_rdata  out  DATA_W  read data, broadcast to all masters (= mem_rdata)
m_ready  out  N_MASTERS  per-master beat acknowledge
mem_valid  out  1  request to memory
mem_addr  out  ADDR_W  granted master's address
mem_wdata  out  DATA_W  granted master's write data
mem_wstrb  out  DATA_W/8  granted master's strobes
mem_rdata  in  DATA_W  memory read data
mem_ready  in  1  memory beat acknowledge
grant_id  out  clog2(N_MASTERS) (min 1)  index of the current/last granted master
busy  out  1  state==GRANT

Behaviour:
- Reset (async): state=IDLE, grant_id=N_MASTERS-1 (so master 0 wins first), beat_cnt=0, mem_valid=0, m_ready=0, busy=0.
- States: IDLE, GRANT. State encodings are in the shared header.
- IDLE:
  - mem_valid=0; all m_ready=0.
  - If any m_valid is high, select the first requesting index scanning from grant_id+1 (mod N_MASTERS), register it into grant_id, clear beat_cnt, and go to GRANT.
  - Arbitration costs 1 bubble cycle.
- GRANT (g=grant_id):
  - mem_valid=m_valid[g]; mem_addr/wdata/wstrb are muxed combinationally from master g.
  - m_ready[g]=mem_ready; other m_ready=0; m_rdata=mem_rdata always.
- Beat accept = mem_valid & mem_ready. On accept, beat_cnt increments; it saturates at MAX_BEATS-1 and wraps only on clear.
- GRANT exits to IDLE when either holds:
  - (a) m_valid[g]=0 (master finished; no memory beat issued that cycle);
  - (b) accept & beat_cnt==MAX_BEATS-1 & any other m_valid high (forced release).
- If (b)'s cap is reached with no other requester, the grant continues and beat_cnt holds at its cap. The next accept with another master pending then releases.
- After release, round-robin excludes g for that arbitration if any other master is requesting. g is re-granted immediately only if it is the sole requester.
- Masters hold m_valid and payload stable from assertion until m_ready. Dropping m_valid before m_ready is a protocol violation; the arbiter just releases, and the memory must tolerate the withdrawn request.
- Reset mid-beat aborts the transfer; mem_valid drops asynchronously with the state.
- mem_ready in IDLE, or while mem_valid=0, is ignored.
- No combinational path from m_valid of non-granted masters to mem_*. mem_ready→m_ready is combinational (zero added latency per beat).

Decomposition:
- Shared header iob_cache_arb.vh: state localparams (IDLE=0, GRANT=1), the GRANT_W=clog2 macro, and the beat-counter width localparam.
- One natural sub-module: iob_rr_prio_enc (N_MASTERS requests + last-grant pointer → one-hot/index next grant plus any_req). It is reusable for other shared ports.

Test Plan:
- Single master: m_valid[0]=1, addr 0x10, wstrb 0xF, wdata 0xDEAD; RAM ready 1 cycle after valid → mem_valid rises 1 cycle after request, mem_addr=0x10, m_ready[0] pulses once, m_ready[1]=0, grant_id=0.
- Simultaneous requests from reset, both reading 4 beats (addr 0..3 / 0x100..0x103) → master 0 completes all 4 beats contiguously, then 1 IDLE bubble, then master 1 with grant_id=1. mem_addr sequence is never interleaved.
- Starvation cap, MAX_BEATS=8: master 0 requests 20 continuous beats; master 1 requests at beat 2 → master 0 is released after its 8th accepted beat, master 1 is served, then master 0 resumes at beat 9 with addresses intact.
- Sole requester at cap: master 0 requests 12 beats alone → no release and no bubble after beat 8; beat_cnt holds at 7.
- Read data routing: masters 0 and 1 each read one word at 0x40/0x44 preloaded with 0x11111111/0x22222222 → each m_ready pulse coincides with m_rdata equal to its own word.
- Async reset asserted mid-GRANT with mem_valid=1 → mem_valid, m_ready and busy are 0 in the same cycle; after release master 0 wins the first arbitration.
